tetromino_renderer: RTL

Parametrised raster renderer that scans a configurable framebuffer-sized pixel grid and drives the VGA adapter write port, painting one selectable, rotatable tetromino on a background colour. It is the next generation of the single static block drawer: shape, rotation, grid position and colour are runtime inputs. Updates enter through a valid/ready handshake and are applied only at frame boundaries, so a frame never shows a torn piece. It sits between game logic (piece state) and the VGA adapter.

---
 rtl/tetromino_renderer_if.sv | 26 ++
 rtl/tetromino_renderer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tetromino_renderer_if.sv
// Piece-update handshake between game logic (master) and the renderer (slave).
// Carries shape, rotation, cell-unit origin and colour alongside valid/ready.
interface tetromino_renderer_if #(
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int CELL_LOG2 = 2,
    parameter int COLOR_W   = 24
) ();
    logic                       upd_valid;
    logic                       upd_ready;
    logic [2:0]                 upd_type;
    logic [1:0]                 upd_rot;
    logic [X_W-CELL_LOG2-1:0]   upd_col;
    logic [Y_W-CELL_LOG2-1:0]   upd_row;
    logic [COLOR_W-1:0]         upd_color;

    modport master (
        output upd_valid, upd_type, upd_rot, upd_col, upd_row, upd_color,
        input  upd_ready
    );

    modport slave (
        input  upd_valid, upd_type, upd_rot, upd_col, upd_row, upd_color,
        output upd_ready
    );
endinterface

// File: rtl/tetromino_renderer.sv
// Raster renderer painting one rotatable tetromino over a background; piece
// updates are double-buffered and swapped at frame end. Optional macro: TETRO_BORDER_EN.
module tetromino_renderer #(
    parameter int H_RES     = 160,
    parameter int V_RES     = 120,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int CELL_LOG2 = 2,
    parameter int COLOR_W   = 24,
    parameter logic [COLOR_W-1:0] BG_COLOR     = COLOR_W'(24'h000000),
    parameter logic [COLOR_W-1:0] BORDER_COLOR = COLOR_W'(24'hFFFFFF)
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    tetromino_renderer_if.slave   upd,
    output logic [X_W-1:0]        VGA_X,
    output logic [Y_W-1:0]        VGA_Y,
    output logic [COLOR_W-1:0]    VGA_COLOR,
    output logic                  plot,
    output logic                  frame_done
);
    localparam int GX_W = X_W - CELL_LOG2;
    localparam int GY_W = Y_W - CELL_LOG2;
    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);
`ifdef TETRO_BORDER_EN
    localparam bit BORDER_EN = 1'b1;
`else
    localparam bit BORDER_EN = 1'b0;
`endif

    // Occupancy of the 4x4 bounding box, bit index = y*4 + x.
    function automatic logic [15:0] piece_mask(input logic [2:0] t, input logic [1:0] r);
        logic [15:0] cells;
        logic [1:0]  n1;
        logic [1:0]  x;
        logic [1:0]  y;
        logic [1:0]  tmp;
        logic [15:0] m;
        n1    = 2'd2;
        cells = 16'h0000;
        case (t)
            3'd0: begin cells = 16'h4567; n1 = 2'd3; end
            3'd1: begin cells = 16'h0145; n1 = 2'd1; end
            3'd2: cells = 16'h1456;
            3'd3: cells = 16'h1245;
            3'd4: cells = 16'h0156;
            3'd5: cells = 16'h0456;
            3'd6: cells = 16'h2456;
            default: cells = 16'h0000;
        endcase
        m = '0;
        for (int i = 0; i < 4; i++) begin
            x = cells[4*i +: 2];
            y = cells[4*i+2 +: 2];
            for (int k = 0; k < 3; k++) begin
                if (k < int'(r)) begin
                    tmp = n1 - y;
                    y   = x;
                    x   = tmp;
                end
            end
            if (t != 3'd7) m[{y, x}] = 1'b1;
        end
        return m;
    endfunction

    logic [X_W-1:0]     sx_reg;
    logic [Y_W-1:0]     sy_reg;
    logic               pend_full_reg;
    logic [15:0]        pend_mask_reg;
    logic [GX_W-1:0]    pend_col_reg;
    logic [GY_W-1:0]    pend_row_reg;
    logic [COLOR_W-1:0] pend_color_reg;
    logic [15:0]        act_mask_reg;
    logic [GX_W-1:0]    act_col_reg;
    logic [GY_W-1:0]    act_row_reg;
    logic [COLOR_W-1:0] act_color_reg;

    logic               last_pixel;
    logic               accept;
    logic [15:0]        upd_mask;
    logic [GX_W-1:0]    dx;
    logic [GY_W-1:0]    dy;
    logic               in_box;
    logic [15:0]        cell_hit;
    logic               hit;
    logic               on_edge;
    logic [COLOR_W-1:0] pix_color;

    assign last_pixel    = (sx_reg == X_LAST) && (sy_reg == Y_LAST);
    assign upd.upd_ready = !pend_full_reg;
    assign accept        = upd.upd_valid && !pend_full_reg;
    assign upd_mask      = piece_mask(upd.upd_type, upd.upd_rot);

    // Negative offsets underflow to large values and fall outside the box.
    assign dx     = sx_reg[X_W-1:CELL_LOG2] - act_col_reg;
    assign dy     = sy_reg[Y_W-1:CELL_LOG2] - act_row_reg;
    assign in_box = (dx[GX_W-1:2] == '0) && (dy[GY_W-1:2] == '0);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_cell
            assign cell_hit[gi] = act_mask_reg[gi]
                                && (dx[1:0] == 2'(gi % 4))
                                && (dy[1:0] == 2'(gi / 4));
        end
    endgenerate

    assign hit     = in_box && (|cell_hit);
    assign on_edge = (sx_reg[CELL_LOG2-1:0] == '0) || (&sx_reg[CELL_LOG2-1:0])
                  || (sy_reg[CELL_LOG2-1:0] == '0) || (&sy_reg[CELL_LOG2-1:0]);

    always_comb begin
        pix_color = BG_COLOR;
        if (hit) pix_color = (BORDER_EN && on_edge) ? BORDER_COLOR : act_color_reg;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sx_reg         <= '0;
            sy_reg         <= '0;
            pend_full_reg  <= 1'b0;
            pend_mask_reg  <= '0;
            pend_col_reg   <= '0;
            pend_row_reg   <= '0;
            pend_color_reg <= BG_COLOR;
            act_mask_reg   <= '0;
            act_col_reg    <= '0;
            act_row_reg    <= '0;
            act_color_reg  <= BG_COLOR;
            VGA_X          <= '0;
            VGA_Y          <= '0;
            VGA_COLOR      <= '0;
            plot           <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            if (sx_reg == X_LAST) begin
                sx_reg <= '0;
                sy_reg <= (sy_reg == Y_LAST) ? '0 : sy_reg + 1'b1;
            end else begin
                sx_reg <= sx_reg + 1'b1;
            end
            // Swap only as the last pixel issues, so the next frame starts clean.
            if (last_pixel && pend_full_reg) begin
                act_mask_reg  <= pend_mask_reg;
                act_col_reg   <= pend_col_reg;
                act_row_reg   <= pend_row_reg;
                act_color_reg <= pend_color_reg;
                pend_full_reg <= 1'b0;
            end
            if (accept) begin
                pend_mask_reg  <= upd_mask;
                pend_col_reg   <= upd.upd_col;
                pend_row_reg   <= upd.upd_row;
                pend_color_reg <= upd.upd_color;
                pend_full_reg  <= 1'b1;
            end
            VGA_X      <= sx_reg;
            VGA_Y      <= sy_reg;
            VGA_COLOR  <= pix_color;
            plot       <= 1'b1;
            frame_done <= last_pixel;
        end
    end
endmodule
